// File: rtl/dec_uart_sender.sv
// Sends a 24-bit three-digit ASCII word as 8N1 UART bytes, hundreds digit first.
// Define NEWLINE_EN to append 0x0D 0x0A after the digits (5-byte frames).
module dec_uart_sender #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] dec_in,
    input  logic        dec_valid,
    output logic        dec_ready,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef NEWLINE_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  baud_cnt_r, baud_cnt_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic [2:0]        byte_idx_r, byte_idx_s;
    logic [23:0]       frame_r, frame_s;
    logic [23:0]       pend_r, pend_s;
    logic              pend_full_r, pend_full_s;
    logic              tx_r, tx_s;
    logic              busy_r, busy_s;
    logic              overrun_r, overrun_s;
    logic              dec_ready_r, dec_ready_s;
    logic              baud_wrap_s;
    logic              frame_end_s;
    logic [7:0]        data_byte_s;

    function automatic logic [7:0] byte_at(input logic [23:0] word, input logic [2:0] idx);
        case (idx)
            3'd0:    return word[23:16];
            3'd1:    return word[15:8];
            3'd2:    return word[7:0];
            3'd3:    return 8'h0D;
            3'd4:    return 8'h0A;
            default: return 8'hFF;
        endcase
    endfunction

    assign baud_wrap_s = (baud_cnt_r == BAUD_LAST);
    assign frame_end_s = (state_r == ST_STOP) && baud_wrap_s && (byte_idx_r == LAST_BYTE);

    // Frame sequencing: bit timing, byte stepping and frame chaining.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        byte_idx_s = byte_idx_r;
        frame_s    = frame_r;
        case (state_r)
            ST_IDLE: begin
                if (dec_valid) begin
                    state_s    = ST_START;
                    frame_s    = dec_in;
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                    byte_idx_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_wrap_s) begin
                    state_s    = ST_DATA;
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_wrap_s) begin
                    baud_cnt_s = '0;
                    if (bit_cnt_r == 3'd7) begin
                        state_s   = ST_STOP;
                        bit_cnt_s = 3'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_wrap_s) begin
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                    if (byte_idx_r != LAST_BYTE) begin
                        byte_idx_s = byte_idx_r + 3'd1;
                        state_s    = ST_START;
                    end else if (pend_full_r) begin
                        // Pending word wins; a strobe in this cycle is dropped.
                        frame_s    = pend_r;
                        byte_idx_s = 3'd0;
                        state_s    = ST_START;
                    end else if (dec_valid) begin
                        frame_s    = dec_in;
                        byte_idx_s = 3'd0;
                        state_s    = ST_START;
                    end else begin
                        byte_idx_s = 3'd0;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = '0;
                bit_cnt_s  = 3'd0;
                byte_idx_s = 3'd0;
            end
        endcase
    end

    // One-entry pending buffer and overrun detection.
    always_comb begin
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        overrun_s   = dec_valid && pend_full_r;
        if (pend_full_r) begin
            pend_full_s = !frame_end_s;
        end else if (dec_valid && (state_r != ST_IDLE) && !frame_end_s) begin
            pend_s      = dec_in;
            pend_full_s = 1'b1;
        end else begin
            pend_full_s = 1'b0;
        end
    end

    // Registered output values derived from the next state.
    always_comb begin
        data_byte_s = byte_at(frame_s, byte_idx_s);
        tx_s        = 1'b1;
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = data_byte_s[bit_cnt_s];
            ST_STOP:  tx_s = 1'b1;
            ST_IDLE:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        busy_s      = (state_s != ST_IDLE);
        dec_ready_s = !pend_full_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= '0;
            bit_cnt_r   <= 3'd0;
            byte_idx_r  <= 3'd0;
            frame_r     <= 24'h000000;
            pend_r      <= 24'h000000;
            pend_full_r <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            dec_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            baud_cnt_r  <= baud_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            byte_idx_r  <= byte_idx_s;
            frame_r     <= frame_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            overrun_r   <= overrun_s;
            dec_ready_r <= dec_ready_s;
        end
    end

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign dec_ready = dec_ready_r;

endmodule

// File: tb/tb_dec_uart_sender.sv
// Self-checking bench for dec_uart_sender: directed scenarios plus random strobes,
// checked every cycle against a frame-level reference model.
module tb_dec_uart_sender;

    localparam int CPB = 8;
`ifdef NEWLINE_EN
    localparam int NB = 5;
`else
    localparam int NB = 3;
`endif
    localparam int FLEN = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] dec_in = 24'h000000;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic        tx;
    logic        busy;
    logic        overrun;

    dec_uart_sender #(.CLK_FREQ(800), .BAUD(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_in    (dec_in),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .tx        (tx),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int busy_seen = 0;

    // Reference model: which word is on the wire and how far into its frame.
    logic        m_active = 1'b0;
    int          m_age = 0;
    logic [23:0] m_word = 24'h000000;
    logic        m_pend = 1'b0;
    logic [23:0] m_pend_word = 24'h000000;
    logic        m_ovr = 1'b0;

    function automatic logic [7:0] tb_byte(input logic [23:0] w, input int b);
        logic [23:0] sh;
        if (b < 3) begin
            sh = w >> (16 - 8 * b);
            return sh[7:0];
        end else if (b == 3) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    function automatic logic exp_tx();
        int b;
        int s;
        logic [7:0] val;
        if (!m_active) return 1'b1;
        b   = m_age / (10 * CPB);
        s   = (m_age % (10 * CPB)) / CPB;
        val = tb_byte(m_word, b);
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return val[s-1];
    endfunction

    task automatic model_step(input logic v, input logic [23:0] d, input logic r);
        logic ending;
        if (!r) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_ovr    = 1'b0;
            m_age    = 0;
        end else begin
            m_ovr  = 1'b0;
            ending = m_active && (m_age == FLEN - 1);
            if (m_active && !ending) begin
                m_age++;
                if (v) begin
                    if (m_pend) begin
                        m_ovr = 1'b1;
                    end else begin
                        m_pend      = 1'b1;
                        m_pend_word = d;
                    end
                end
            end else if (m_pend) begin
                m_word   = m_pend_word;
                m_pend   = 1'b0;
                m_active = 1'b1;
                m_age    = 0;
                m_ovr    = v;
            end else if (v) begin
                m_word   = d;
                m_active = 1'b1;
                m_age    = 0;
            end else begin
                m_active = 1'b0;
            end
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic tick(input logic v, input logic [23:0] d);
        dec_valid = v;
        dec_in    = d;
        @(posedge clk);
        model_step(v, d, rst_n);
        @(negedge clk);
        cyc++;
        chk1("tx", tx, exp_tx());
        chk1("busy", busy, m_active);
        chk1("dec_ready", dec_ready, !m_pend);
        chk1("overrun", overrun, m_ovr);
        if (busy === 1'b1) busy_seen++;
        dec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * FLEN; i++) begin
            if (busy !== 1'b1) break;
            tick(1'b0, 24'h000000);
        end
        chk1("wait_idle", busy, 1'b0);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        tick(1'b0, 24'h000000);
        tick(1'b0, 24'h000000);
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", dec_ready, 1'b1);
        chk1("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 24'h000000);

        // Single "255" frame: start bit right after strobe, exact busy length
        busy_seen = 0;
        tick(1'b1, 24'h323535);
        chk1("start_latency", tx, 1'b0);
        wait_idle();
        chkn("busy_len_single", busy_seen, FLEN);
        repeat (5) tick(1'b0, 24'h000000);

        // Chained frame from pending plus a dropped third word
        busy_seen = 0;
        tick(1'b1, 24'h303030);
        repeat (49) tick(1'b0, 24'h000000);
        tick(1'b1, 24'h313030);
        chkn("ready_drop", int'(dec_ready), 0);
        tick(1'b1, 24'h777777);
        chk1("overrun_pulse", overrun, 1'b1);
        tick(1'b0, 24'h000000);
        chk1("overrun_clear", overrun, 1'b0);
        wait_idle();
        chkn("busy_len_chain", busy_seen, 2 * FLEN);
        repeat (4) tick(1'b0, 24'h000000);

        // Strobe exactly on a frame end with empty buffer: direct load, no gap
        busy_seen = 0;
        tick(1'b1, 24'h313238);
        repeat (FLEN - 1) tick(1'b0, 24'h000000);
        tick(1'b1, 24'h393939);
        wait_idle();
        chkn("busy_len_endload", busy_seen, 2 * FLEN);

        // Strobe on a frame end with buffer full: dropped with overrun
        busy_seen = 0;
        tick(1'b1, 24'h414243);
        tick(1'b1, 24'h444546);
        repeat (FLEN - 2) tick(1'b0, 24'h000000);
        tick(1'b1, 24'h474849);
        chk1("end_full_overrun", overrun, 1'b1);
        wait_idle();
        chkn("busy_len_endfull", busy_seen, 2 * FLEN);

        // Reset during DATA bit 3 of byte 1 with buffer full
        tick(1'b1, 24'h353535);
        tick(1'b1, 24'h363636);
        repeat (112) tick(1'b0, 24'h000000);
        chk1("pre_rst_ready", dec_ready, 1'b0);
        rst_n = 1'b0;
        tick(1'b0, 24'h000000);
        chk1("midrst_tx", tx, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_ready", dec_ready, 1'b1);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (2 * FLEN) tick(1'b0, 24'h000000);
        chkn("post_rst_silent", busy_seen, 0);

        // Random strobes and words
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0, 24'($urandom));
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dec_uart_sender.md
Name: dec_uart_sender

Overview:
Downstream stage of the binary-to-decimal ASCII converter. Takes the 24-bit three-digit ASCII word and transmits it as three 8N1 UART bytes on a single tx line, hundreds digit first.
- One-entry pending buffer absorbs a new word that arrives while a frame is still on the wire.
- Together with the upstream receiver and converter, closes the echo loop back to the host terminal.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
dec_in  input  24  ASCII digits {hundreds, tens, units}; bits [23:16] are sent first
dec_valid  input  1  single-cycle strobe; dec_in is valid in that cycle
dec_ready  output  1  high when a dec_valid this cycle will be accepted; equals ~pend_full
tx  output  1  UART line, idle high
busy  output  1  high while a frame is being shifted out
overrun  output  1  one-cycle pulse, the cycle after a dec_valid arrives while dec_ready is low

Behaviour:
- Reset (rst_n low at a clk edge), taking effect next cycle:
  - Outputs: tx=1, busy=0, overrun=0, dec_ready=1.
  - Internal state: pending buffer empty, FSM=IDLE, baud counter 0, bit counter 0, byte index 0.
  - Reset mid-frame aborts immediately. No partial byte is resumed and the pending word is lost.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, or at a frame end with the buffer empty: dec_valid loads the word directly into the active frame. FSM goes to START and busy=1 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte index < last: increment it and go to START with no idle gap.
    - Otherwise the frame ends: if the pending buffer is full, load it, clear it and go to START; else go to IDLE with busy=0.
- Pending buffer:
  - dec_valid while the FSM is not idle and the buffer is empty: dec_in is stored and pend_full=1 next cycle.
  - dec_valid while pend_full=1: the word is dropped, overrun pulses for one cycle, and the frame in flight is unaffected.
  - dec_valid in the same cycle a frame ends with the buffer empty: loads directly, same as IDLE.
  - dec_valid in the same cycle a frame ends with the buffer full: dropped, because dec_ready is still low in that cycle.
- Latency: dec_valid at edge N (IDLE) gives tx=0 from cycle N+1.
  - Frame length = bytes x 10 x CLKS_PER_BIT cycles, where bytes = 3, or 5 with the optional feature.
  - busy stays high for exactly that many cycles per frame. When a frame chains from pending, busy stays high with no gap.
- Data is sent raw. Bytes are not range-checked, so a non-digit value is transmitted as-is.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit counter counts 0..7. Byte index counts 0..bytes-1.

Optional Feature:
Macro NEWLINE_EN.
- Defined: each frame is 5 bytes, the three digits followed by 0x0D then 0x0A. Frame length is 50 x CLKS_PER_BIT cycles.
- Undefined: each frame is 3 bytes, 30 x CLKS_PER_BIT cycles, with no trailing bytes.
- All handshake, overrun and reset rules are identical in both builds.

Test Plan:
- CLK_FREQ=800, BAUD=100 (CLKS_PER_BIT=8), NEWLINE_EN off. Check:
  - Reset: tx=1, busy=0, dec_ready=1, overrun=0.
  - Pulse dec_valid with dec_in=0x323535 ("255") -> decoded line bytes 0x32, 0x35, 0x35 with correct start/stop bits.
  - busy is high for exactly 240 cycles; tx=0 appears on the cycle after the strobe.
- Send 0x303030, then pulse 0x313030 at cycle 50 -> dec_ready drops at cycle 51. The second frame starts on the cycle after the first frame's final stop bit, with no idle gap: 480 busy cycles total and bytes 30 30 30 31 30 30.
- While busy with the buffer full, pulse a third word -> overrun=1 for exactly one cycle and the dropped word never appears on tx.
- Assert rst_n=0 during the DATA bit 3 of byte 1, with the buffer full -> next cycle tx=1, busy=0, dec_ready=1. After release, nothing is transmitted until a new dec_valid.
- NEWLINE_EN defined, dec_in=0x313238 ("128") -> bytes 31 32 38 0D 0A and busy for 400 cycles.
